// File: rtl/pooling_input_ctrl.sv
// rtl/pooling_input_ctrl.sv - sequencer for the pooling input serialiser (load pulse, element tags, frame done)
// Optional build macro: POOL_CTRL_OVERLAP_EN (accept the next word during the last element of a burst)
module pooling_input_ctrl #(
    parameter int KERNEL_SIZE     = 2,
    parameter int WORDS_PER_BLOCK = 3,
    parameter int NUM_BLOCK       = 4,
    parameter int CNT_W           = 4,
    localparam int EW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          load_en,
    output logic [2:0]    block_idx,
    output logic          elem_valid,
    output logic [EW-1:0] elem_idx,
    output logic          elem_last,
    output logic          block_last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [EW-1:0]    LAST_ELEM = EW'(KERNEL_SIZE - 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [2:0]       LAST_BLK  = 3'(NUM_BLOCK - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] word_cnt;
    logic             word_last;
    logic             frame_last;

    assign elem_last  = (state == S_SHIFT) && (elem_idx == LAST_ELEM);
    assign word_last  = (word_cnt == LAST_WORD);
    assign block_last = elem_last && word_last;
    assign frame_last = block_last && (block_idx == LAST_BLK);
    assign load_en    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_WAIT;
            S_WAIT:  if (in_valid) next_state = S_SHIFT;
            S_SHIFT: begin
                if (elem_last) begin
                    if (frame_last) begin
                        next_state = S_DONE;
                    end else if (load_en) begin
                        next_state = S_SHIFT;
                    end else begin
                        next_state = S_WAIT;
                    end
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        elem_valid = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE:  busy = 1'b0;
            S_WAIT:  in_ready = 1'b1;
            S_SHIFT: begin
                elem_valid = 1'b1;
`ifdef POOL_CTRL_OVERLAP_EN
                // The last word of the frame must drain into DONE, so no overlap there.
                in_ready = elem_last && !frame_last;
`else
                in_ready = 1'b0;
`endif
            end
            S_DONE:  done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Word/block bookkeeping advances on the elem_last cycle, whether the next word arrives via WAIT or overlap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            block_idx <= 3'd0;
            word_cnt  <= '0;
            elem_idx  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        block_idx <= 3'd0;
                        word_cnt  <= '0;
                        elem_idx  <= '0;
                    end
                end
                S_WAIT: elem_idx <= '0;
                S_SHIFT: begin
                    if (!elem_last) begin
                        elem_idx <= elem_idx + EW'(1);
                    end else begin
                        elem_idx <= '0;
                        if (word_last) begin
                            word_cnt <= '0;
                            if (block_idx != LAST_BLK) begin
                                block_idx <= block_idx + 3'd1;
                            end
                        end else begin
                            word_cnt <= word_cnt + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pooling_input_ctrl.sv
// tb/tb_pooling_input_ctrl.sv - scoreboard bench for pooling_input_ctrl
module tb_pooling_input_ctrl;

    localparam int K     = 2;
    localparam int WPB   = 3;
    localparam int NB    = 4;
    localparam int WORDS = WPB * NB;
`ifdef POOL_CTRL_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic       load_en;
    logic [2:0] block_idx;
    logic       elem_valid;
    logic [0:0] elem_idx;
    logic       elem_last;
    logic       block_last;
    logic       busy;
    logic       done;

    pooling_input_ctrl #(
        .KERNEL_SIZE(K), .WORDS_PER_BLOCK(WPB), .NUM_BLOCK(NB), .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .load_en(load_en), .block_idx(block_idx),
        .elem_valid(elem_valid), .elem_idx(elem_idx), .elem_last(elem_last),
        .block_last(block_last), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int blk;
        int idx;
        bit last;
        bit blast;
        bit fin;
    } elem_t;

    elem_t sb[$];
    int    tests = 0;
    int    fails = 0;
    int    r = 0;
    int    cur_mode = 0;
    int    n_loads = 0;
    bit    exp_done_next = 0;
    bit    exp_first_shift = 0;
    bit    exp_reset_out = 0;
    int    load_cyc[$];
    int    blast_cyc[$];
    int    done_cyc[$];

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, r, got, exp);
        end
    endtask

    task automatic monitor();
        elem_t e;
        if (exp_reset_out) begin
            check("reset_outputs", int'({in_ready, load_en, block_idx, elem_valid, elem_idx,
                                         elem_last, block_last, busy, done}), 0);
            exp_reset_out = 0;
        end
        check("load_en_handshake", int'(load_en), int'(in_valid & in_ready));
        if (exp_first_shift) begin
            check("first_shift_valid", int'(elem_valid), 1);
            exp_first_shift = 0;
        end
        if (exp_done_next) begin
            check("done_timing", int'(done), 1);
            exp_done_next = 0;
        end else if (done) begin
            check("done_unexpected", 1, 0);
        end
        if (done) check("busy_in_done", int'(busy), 1);
        if (cur_mode == 2 && r >= 6 && r <= 8) begin
            check("stall_no_elem", int'(elem_valid), 0);
            check("stall_block_idx", int'(block_idx), 0);
        end
        if (elem_valid) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 0, 1);
            end else begin
                e = sb.pop_front();
                check("block_idx", int'(block_idx), e.blk);
                check("elem_idx", int'(elem_idx), e.idx);
                check("elem_last", int'(elem_last), int'(e.last));
                check("block_last", int'(block_last), int'(e.blast));
                check("shift_in_ready", int'(in_ready), (OVL && e.last && !e.fin) ? 1 : 0);
                check("shift_busy", int'(busy), 1);
                if (block_last) blast_cyc.push_back(r);
                if (e.fin && e.last) exp_done_next = 1;
            end
        end else begin
            check("tags_idle", int'({elem_last, block_last}), 0);
        end
        if (load_en) begin
            load_cyc.push_back(r);
            for (int i = 0; i < K; i++) begin
                e.blk   = n_loads / WPB;
                e.idx   = i;
                e.last  = (i == K - 1);
                e.blast = e.last && ((n_loads % WPB) == WPB - 1);
                e.fin   = (n_loads == WORDS - 1);
                sb.push_back(e);
            end
            n_loads++;
            exp_first_shift = 1;
        end
        if (done) begin
            done_cyc.push_back(r);
            check("frame_loads", n_loads, WORDS);
            check("sb_drained", sb.size(), 0);
            n_loads = 0;
        end
        if (!rst_n) begin
            sb.delete();
            n_loads = 0;
            exp_done_next = 0;
            exp_first_shift = 0;
            exp_reset_out = 1;
        end
    endtask

    task automatic step(input bit s, input bit v, input bit rn);
        start    = s;
        in_valid = v;
        rst_n    = rn;
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        r++;
    endtask

    // mode 1: plain frame, 2: in_valid stall, 3: stray starts, 4: reset mid-frame
    task automatic run_frame(input int mode);
        bit s;
        bit v;
        bit rn;
        bit finished;
        cur_mode = mode;
        load_cyc.delete();
        blast_cyc.delete();
        done_cyc.delete();
        r = 0;
        finished = 0;
        while (!finished && r < 200) begin
            s  = (r == 0) || (mode == 3 && (r == 5 || r == 20));
            v  = !(mode == 2 && r >= 4 && r <= 8);
            rn = !(mode == 4 && r == 10);
            step(s, v, rn);
            if (mode == 4 && r >= 16) finished = 1;
            if (mode != 4 && done_cyc.size() > 0 && r >= done_cyc[0] + 3) finished = 1;
        end
        if (!finished) check("frame_timeout", 0, 1);
        check("idle_busy", int'(busy), 0);
        if (mode == 4) begin
            check("abort_no_done", done_cyc.size(), 0);
        end else begin
            check("done_count", done_cyc.size(), 1);
            check("load_count", load_cyc.size(), WORDS);
            check("block_last_count", blast_cyc.size(), NB);
        end
        if (mode == 1) begin
            foreach (load_cyc[k]) check("load_cycle", load_cyc[k], 1 + (OVL ? 2 : 3) * k);
            foreach (blast_cyc[b]) check("block_last_cycle", blast_cyc[b], OVL ? 7 + 6 * b : 9 + 9 * b);
            if (done_cyc.size() > 0) check("done_cycle", done_cyc[0], OVL ? 26 : 37);
        end
    endtask

    initial begin
        start    = 1'b0;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 1);
        run_frame(1);
        run_frame(2);
        run_frame(4);
        run_frame(1);
        run_frame(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
